// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the bus arbiter: FSM state encoding, default
// parameter values and the wait-counter width.
// Ports: none (package).
// ---------------------------------------------------------------------------
package arb_pkg;

  localparam int unsigned DEF_NUM_MASTERS = 2;
  localparam int unsigned DEF_ADDR_W      = 19;
  localparam int unsigned DEF_DATA_W      = 16;
  localparam int unsigned DEF_RR_MODE     = 1;
  localparam int unsigned DEF_TIMEOUT     = 255;

  // Width of the GRANT wait counter; TIMEOUT is limited to 1..65535.
  localparam int unsigned WAIT_W = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Next index in a ring of n entries.
  function automatic int unsigned wrap_next(input int unsigned idx, input int unsigned n);
    return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// bus_arbiter_if
// Bundles the per-master request bus, the shared slave bus and the arbiter
// status outputs.
//   m_*           : packed per-master vectors, master i at slice i
//   q_m_*         : shared slave bus (q_m_data_in / q_m_ack are OR-combined
//                   slave returns)
//   grant_active, grant_idx, timeout_err : arbiter status
// Modports:
//   slave  : the arbiter (serves the masters, drives the slave bus)
//   master : the environment (masters plus slaves) around the arbiter
// q_m_addr is a word address: bit 0 of the vector carries byte-address bit 1.
// ---------------------------------------------------------------------------
interface bus_arbiter_if import arb_pkg::*; #(
  parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W
);

  localparam int unsigned IDX_W  = $clog2(NUM_MASTERS);
  localparam int unsigned BSEL_W = DATA_W / 8;

  // Per-master side
  logic [NUM_MASTERS*ADDR_W-1:0] m_addr;
  logic [NUM_MASTERS*DATA_W-1:0] m_data_out;
  logic [NUM_MASTERS-1:0]        m_access;
  logic [NUM_MASTERS-1:0]        m_wr_en;
  logic [NUM_MASTERS*BSEL_W-1:0] m_bytesel;
  logic [NUM_MASTERS*DATA_W-1:0] m_data_in;
  logic [NUM_MASTERS-1:0]        m_ack;

  // Shared slave side
  logic [ADDR_W-1:0]             q_m_addr;
  logic [DATA_W-1:0]             q_m_data_out;
  logic                          q_m_wr_en;
  logic [BSEL_W-1:0]             q_m_bytesel;
  logic                          q_m_access;
  logic [DATA_W-1:0]             q_m_data_in;
  logic                          q_m_ack;

  // Status
  logic                          grant_active;
  logic [IDX_W-1:0]              grant_idx;
  logic                          timeout_err;

  modport slave (
    input  m_addr, m_data_out, m_access, m_wr_en, m_bytesel,
    input  q_m_data_in, q_m_ack,
    output m_data_in, m_ack,
    output q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel, q_m_access,
    output grant_active, grant_idx, timeout_err
  );

  modport master (
    output m_addr, m_data_out, m_access, m_wr_en, m_bytesel,
    output q_m_data_in, q_m_ack,
    input  m_data_in, m_ack,
    input  q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel, q_m_access,
    input  grant_active, grant_idx, timeout_err
  );

endinterface

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational rotating priority encoder: returns the first set bit of req
// found when scanning upward from index base, wrapping modulo N.
//   req   : request vector
//   base  : index with highest priority (0 gives plain lowest-index priority)
//   idx   : selected index (0 when nothing is requested)
//   valid : at least one request is present
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scan N positions starting at base; the first hit wins.
  always_comb begin
    int unsigned pos;
    idx   = '0;
    valid = 1'b0;
    pos   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = (32'(base) + i) % N;
      if (!valid && req[IW'(pos)]) begin
        valid = 1'b1;
        idx   = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
// Arbitrates NUM_MASTERS request/ack masters onto one shared slave bus.
// An IDLE/GRANT FSM registers a winner (round-robin or fixed priority), then
// routes the owner's request to the slave bus until the slave acks, the
// owner withdraws, or the wait counter hits TIMEOUT-1 (which answers the
// owner with all-ones data and a timeout_err pulse).
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : bus_arbiter_if.slave -- master request bus, shared slave bus
//           and status (grant_active, grant_idx, timeout_err)
// ---------------------------------------------------------------------------
module bus_arbiter import arb_pkg::*; #(
  parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned RR_MODE     = DEF_RR_MODE,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic         clk,
  input  logic         reset,
  bus_arbiter_if.slave bus
);

  localparam int unsigned       IDX_W     = $clog2(NUM_MASTERS);
  localparam int unsigned       BSEL_W    = DATA_W / 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  arb_state_e                    state_q, state_d;
  logic [IDX_W-1:0]              grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]              rr_ptr_q, rr_ptr_d;
  logic [WAIT_W-1:0]             wait_q, wait_d;

  logic [IDX_W-1:0]              pick_base;
  logic [IDX_W-1:0]              pick_idx;
  logic                          pick_valid;

  logic                          owner_req;
  logic                          done_ack;
  logic                          done_to;

  logic [ADDR_W-1:0]             sel_addr;
  logic [DATA_W-1:0]             sel_data;
  logic                          sel_wr;
  logic [BSEL_W-1:0]             sel_bsel;

  logic [NUM_MASTERS-1:0]        ack_vec;
  logic [NUM_MASTERS*DATA_W-1:0] rdata_vec;

  // Fixed priority is the rotating encoder pinned at base 0.
  assign pick_base = (RR_MODE != 0) ? rr_ptr_q : '0;

  rr_pick #(
    .N (NUM_MASTERS)
  ) u_rr_pick (
    .req   (bus.m_access),
    .base  (pick_base),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Owner's request and slave-bus mux; the bus parks at fixed values in IDLE.
  always_comb begin
    owner_req = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    sel_wr    = 1'b0;
    sel_bsel  = '1;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (grant_idx_q == IDX_W'(i)) begin
        owner_req = bus.m_access[i];
        if (state_q == GRANT) begin
          sel_addr = bus.m_addr[i*ADDR_W +: ADDR_W];
          sel_data = bus.m_data_out[i*DATA_W +: DATA_W];
          sel_wr   = bus.m_wr_en[i];
          sel_bsel = bus.m_bytesel[i*BSEL_W +: BSEL_W];
        end
      end
    end
  end

  // Next-state logic: slave ack beats owner withdrawal beats timeout.
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    wait_d      = wait_q;
    done_ack    = 1'b0;
    done_to     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d     = GRANT;
          grant_idx_d = pick_idx;
          wait_d      = '0;
        end
      end
      GRANT: begin
        if (bus.q_m_ack) begin
          done_ack = 1'b1;
          state_d  = IDLE;
        end else if (!owner_req) begin
          state_d  = IDLE;
        end else if (wait_q == WAIT_LAST) begin
          done_to  = 1'b1;
          state_d  = IDLE;
        end else begin
          wait_d   = wait_q + WAIT_W'(1);
        end
        // Any end of grant moves the round-robin pointer past the owner.
        if (state_d == IDLE) begin
          rr_ptr_d = IDX_W'(wrap_next(32'(grant_idx_q), NUM_MASTERS));
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Completion back to the owner only; everyone else sees zeros.
  always_comb begin
    ack_vec   = '0;
    rdata_vec = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (grant_idx_q == IDX_W'(i)) begin
        ack_vec[i] = done_ack | done_to;
        if (done_ack) begin
          rdata_vec[i*DATA_W +: DATA_W] = bus.q_m_data_in;
        end else if (done_to) begin
          rdata_vec[i*DATA_W +: DATA_W] = {DATA_W{1'b1}};
        end
      end
    end
  end

  // State register; reset aborts any grant in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      wait_q      <= wait_d;
    end
  end

  // q_m_access drops in the ack cycle so the slave never sees a second beat.
  assign bus.q_m_access   = (state_q == GRANT) & owner_req & ~bus.q_m_ack;
  assign bus.q_m_addr     = sel_addr;
  assign bus.q_m_data_out = sel_data;
  assign bus.q_m_wr_en    = sel_wr;
  assign bus.q_m_bytesel  = sel_bsel;

  assign bus.m_ack        = ack_vec;
  assign bus.m_data_in    = rdata_vec;

  assign bus.grant_active = (state_q == GRANT);
  assign bus.grant_idx    = grant_idx_q;
  assign bus.timeout_err  = done_to;

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
// Directed bench: dut_a (2 masters, round-robin, TIMEOUT=8) and
// dut_b (4 masters, fixed priority). Inputs change and outputs are sampled
// around the falling edge.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  bus_arbiter_if #(.NUM_MASTERS(2), .ADDR_W(19), .DATA_W(16)) bus_a ();
  bus_arbiter_if #(.NUM_MASTERS(4), .ADDR_W(19), .DATA_W(16)) bus_b ();

  bus_arbiter #(
    .NUM_MASTERS (2),
    .ADDR_W      (19),
    .DATA_W      (16),
    .RR_MODE     (1),
    .TIMEOUT     (8)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  bus_arbiter #(
    .NUM_MASTERS (4),
    .ADDR_W      (19),
    .DATA_W      (16),
    .RR_MODE     (0),
    .TIMEOUT     (255)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] d;
    reset = 1'b1;
    bus_a.m_addr = '0; bus_a.m_data_out = '0; bus_a.m_access = '0;
    bus_a.m_wr_en = '0; bus_a.m_bytesel = '0;
    bus_a.q_m_data_in = '0; bus_a.q_m_ack = 1'b0;
    bus_b.m_addr = '0; bus_b.m_data_out = '0; bus_b.m_access = '0;
    bus_b.m_wr_en = '0; bus_b.m_bytesel = '0;
    bus_b.q_m_data_in = '0; bus_b.q_m_ack = 1'b0;

    // Reset state
    nxt(); #1;
    chk("rst_grant_active", 64'(bus_a.grant_active), 64'd0);
    chk("rst_grant_idx",    64'(bus_a.grant_idx),    64'd0);
    chk("rst_q_access",     64'(bus_a.q_m_access),   64'd0);
    chk("rst_m_ack",        64'(bus_a.m_ack),        64'd0);
    chk("rst_timeout_err",  64'(bus_a.timeout_err),  64'd0);
    chk("rst_q_bytesel",    64'(bus_a.q_m_bytesel),  64'h3);
    chk("rst_q_addr",       64'(bus_a.q_m_addr),     64'd0);
    nxt(); reset = 1'b0;

    // Slave ack while idle is ignored
    nxt(); bus_a.q_m_ack = 1'b1; bus_a.q_m_data_in = 16'hBEEF; #1;
    chk("idle_ack_m_ack",   64'(bus_a.m_ack),       64'd0);
    chk("idle_ack_rdata",   64'(bus_a.m_data_in),   64'd0);
    chk("idle_ack_to",      64'(bus_a.timeout_err), 64'd0);
    nxt(); bus_a.q_m_ack = 1'b0; #1;
    chk("idle_ack_state",   64'(bus_a.grant_active), 64'd0);

    // Master 1 write: shared bus follows master 1 exactly
    nxt();
    bus_a.m_addr[0 +: 19]     = 19'h00123;
    bus_a.m_data_out[0 +: 16] = 16'h1111;
    bus_a.m_bytesel[0 +: 2]   = 2'b10;
    bus_a.m_addr[19 +: 19]    = 19'h05000;
    bus_a.m_data_out[16 +: 16] = 16'hABCD;
    bus_a.m_bytesel[2 +: 2]   = 2'b01;
    bus_a.m_wr_en             = 2'b10;
    bus_a.m_access            = 2'b10;
    #1;
    chk("wr_idle_q_access", 64'(bus_a.q_m_access), 64'd0);
    chk("wr_idle_q_addr",   64'(bus_a.q_m_addr),   64'd0);
    chk("wr_idle_q_bsel",   64'(bus_a.q_m_bytesel), 64'h3);
    nxt(); #1;
    chk("wr_grant_idx",     64'(bus_a.grant_idx),    64'd1);
    chk("wr_grant_active",  64'(bus_a.grant_active), 64'd1);
    chk("wr_q_access",      64'(bus_a.q_m_access),   64'd1);
    chk("wr_q_addr",        64'(bus_a.q_m_addr),     64'h05000);
    chk("wr_q_data",        64'(bus_a.q_m_data_out), 64'hABCD);
    chk("wr_q_wr_en",       64'(bus_a.q_m_wr_en),    64'd1);
    chk("wr_q_bsel",        64'(bus_a.q_m_bytesel),  64'h1);
    nxt(); bus_a.q_m_ack = 1'b1; bus_a.q_m_data_in = 16'h0000; #1;
    chk("wr_ack_q_access",  64'(bus_a.q_m_access), 64'd0);
    chk("wr_ack_m_ack",     64'(bus_a.m_ack),      64'h2);
    nxt(); bus_a.q_m_ack = 1'b0; bus_a.m_access = 2'b00; bus_a.m_wr_en = 2'b00; #1;
    chk("wr_done_state",    64'(bus_a.grant_active), 64'd0);
    chk("wr_done_m_ack",    64'(bus_a.m_ack),        64'd0);

    // Owner withdraws without ack: no ack, pointer still advances
    nxt(); bus_a.m_access = 2'b01; #1;
    nxt(); #1;
    chk("drop_grant_idx",   64'(bus_a.grant_idx),  64'd0);
    chk("drop_q_access_on", 64'(bus_a.q_m_access), 64'd1);
    nxt(); bus_a.m_access = 2'b00; #1;
    chk("drop_q_access",    64'(bus_a.q_m_access), 64'd0);
    chk("drop_m_ack",       64'(bus_a.m_ack),      64'd0);
    nxt(); bus_a.m_access = 2'b11; #1;
    chk("drop_idle",        64'(bus_a.grant_active), 64'd0);
    nxt(); #1;
    chk("drop_rr_next",     64'(bus_a.grant_idx), 64'd1);
    nxt(); bus_a.m_access = 2'b00; #1;
    nxt(); #1;
    chk("drop2_idle",       64'(bus_a.grant_active), 64'd0);

    // Both masters request constantly, slave acks one cycle after access
    for (int g = 0; g < 4; g++) begin
      d = 16'h1111 * 16'(g + 1);
      nxt(); bus_a.q_m_ack = 1'b0; bus_a.m_access = 2'b11; #1;
      chk("rr_idle_gap",    64'(bus_a.grant_active), 64'd0);
      nxt(); #1;
      chk("rr_grant_idx",   64'(bus_a.grant_idx),   64'(g % 2));
      chk("rr_q_access",    64'(bus_a.q_m_access),  64'd1);
      nxt(); bus_a.q_m_ack = 1'b1; bus_a.q_m_data_in = d; #1;
      chk("rr_m_ack",       64'(bus_a.m_ack),       (g % 2 == 0) ? 64'h1 : 64'h2);
      chk("rr_m_data_in",   64'(bus_a.m_data_in),
          (g % 2 == 0) ? 64'({16'h0000, d}) : 64'({d, 16'h0000}));
    end
    nxt(); bus_a.q_m_ack = 1'b0; bus_a.m_access = 2'b00; #1;

    // Slave never acks: timeout in the 8th grant cycle, then master 1 granted
    nxt(); bus_a.m_access = 2'b11; #1;
    chk("to_idle",          64'(bus_a.grant_active), 64'd0);
    for (int k = 1; k <= 7; k++) begin
      nxt(); #1;
      chk("to_wait_q_access", 64'(bus_a.q_m_access),  64'd1);
      chk("to_wait_err",      64'(bus_a.timeout_err), 64'd0);
      chk("to_wait_m_ack",    64'(bus_a.m_ack),       64'd0);
    end
    nxt(); #1;
    chk("to_m_ack",         64'(bus_a.m_ack),        64'h1);
    chk("to_m_data_in",     64'(bus_a.m_data_in),    64'h0000FFFF);
    chk("to_err",           64'(bus_a.timeout_err),  64'd1);
    chk("to_grant_idx",     64'(bus_a.grant_idx),    64'd0);
    nxt(); bus_a.m_access = 2'b10; #1;
    chk("to_after_err",     64'(bus_a.timeout_err),  64'd0);
    chk("to_after_idle",    64'(bus_a.grant_active), 64'd0);
    nxt(); #1;
    chk("to_next_idx",      64'(bus_a.grant_idx),    64'd1);
    chk("to_next_active",   64'(bus_a.grant_active), 64'd1);

    // Slave ack in the 8th grant cycle wins over the timeout
    for (int k = 2; k <= 7; k++) begin
      nxt(); #1;
      chk("late_wait_err",  64'(bus_a.timeout_err), 64'd0);
    end
    nxt(); bus_a.q_m_ack = 1'b1; bus_a.q_m_data_in = 16'h5A5A; #1;
    chk("late_m_ack",       64'(bus_a.m_ack),       64'h2);
    chk("late_m_data_in",   64'(bus_a.m_data_in),   64'h5A5A0000);
    chk("late_err",         64'(bus_a.timeout_err), 64'd0);
    nxt(); bus_a.q_m_ack = 1'b0; bus_a.m_access = 2'b00; #1;

    // Reset mid-grant: access drops at once, owner index returns to 0
    nxt(); bus_a.m_access = 2'b10; #1;
    nxt(); #1;
    chk("rg_grant_idx",     64'(bus_a.grant_idx),  64'd1);
    chk("rg_q_access_on",   64'(bus_a.q_m_access), 64'd1);
    #2; reset = 1'b1; bus_a.m_access = 2'b00; #1;
    chk("rg_q_access",      64'(bus_a.q_m_access),   64'd0);
    chk("rg_active",        64'(bus_a.grant_active), 64'd0);
    chk("rg_m_ack",         64'(bus_a.m_ack),        64'd0);
    nxt(); reset = 1'b0; #1;
    chk("rg_rel_idx",       64'(bus_a.grant_idx),    64'd0);
    chk("rg_rel_active",    64'(bus_a.grant_active), 64'd0);
    nxt(); bus_a.m_access = 2'b11; #1;
    nxt(); #1;
    chk("rg_rr_restart",    64'(bus_a.grant_idx), 64'd0);
    nxt(); bus_a.m_access = 2'b00; #1;

    // Fixed priority with 4 masters: master 3 waits until master 1 stops
    nxt(); bus_b.m_access = 4'b1010; #1;
    chk("fp_idle",          64'(bus_b.grant_active), 64'd0);
    nxt(); #1;
    chk("fp_first_idx",     64'(bus_b.grant_idx), 64'd1);
    nxt(); bus_b.q_m_ack = 1'b1; bus_b.q_m_data_in = 16'h0101; #1;
    chk("fp_first_ack",     64'(bus_b.m_ack),     64'h2);
    chk("fp_first_data",    bus_b.m_data_in,      64'h0000_0000_0101_0000);
    nxt(); bus_b.q_m_ack = 1'b0; #1;
    chk("fp_gap",           64'(bus_b.grant_active), 64'd0);
    nxt(); #1;
    chk("fp_again_idx",     64'(bus_b.grant_idx), 64'd1);
    nxt(); bus_b.q_m_ack = 1'b1; bus_b.q_m_data_in = 16'h0202; #1;
    chk("fp_again_ack",     64'(bus_b.m_ack),     64'h2);
    nxt(); bus_b.q_m_ack = 1'b0; bus_b.m_access = 4'b1000; #1;
    nxt(); #1;
    chk("fp_m3_idx",        64'(bus_b.grant_idx), 64'd3);
    nxt(); bus_b.q_m_ack = 1'b1; bus_b.q_m_data_in = 16'h3333; #1;
    chk("fp_m3_ack",        64'(bus_b.m_ack),     64'h8);
    chk("fp_m3_data",       bus_b.m_data_in,      64'h3333_0000_0000_0000);
    nxt(); bus_b.q_m_ack = 1'b0; bus_b.m_access = 4'b0000; #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001: Parameter NUM_MASTERS, default 2: number of requesting masters, 2..8.
REQ-002: Parameter ADDR_W, default 19: word-address width, bits [ADDR_W:1].
REQ-003: Parameter DATA_W, default 16: data width; bytesel width is DATA_W/8.
REQ-004: Parameter RR_MODE, default 1: 1 = round-robin; 0 = fixed priority, index 0 highest.
REQ-005: Parameter TIMEOUT, default 255: maximum cycles in GRANT awaiting q_m_ack, 1..65535.
REQ-006: clk  input  1  single clock; all logic on posedge clk.
REQ-007: reset  input  1  asynchronous, active-high reset.
REQ-008: m_addr  input  NUM_MASTERS*ADDR_W  per-master word address, master i at slice i.
REQ-009: m_data_out  input  NUM_MASTERS*DATA_W  per-master write data.
REQ-010: m_access  input  NUM_MASTERS  per-master request, held until its ack.
REQ-011: m_wr_en  input  NUM_MASTERS  per-master write enable.
REQ-012: m_bytesel  input  NUM_MASTERS*DATA_W/8  per-master byte enables.
REQ-013: m_data_in  output  NUM_MASTERS*DATA_W  per-master read data.
REQ-014: m_ack  output  NUM_MASTERS  per-master one-cycle completion pulse.
REQ-015: q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel  output  ADDR_W, DATA_W, 1, DATA_W/8  shared slave bus.
REQ-016: q_m_access  output  1  slave request.
REQ-017: q_m_data_in  input  DATA_W  OR-combined slave read data.
REQ-018: q_m_ack  input  1  OR-combined slave ack.
REQ-019: grant_active  output  1  high in GRANT; grant_idx  output  $clog2(NUM_MASTERS)  current owner.
REQ-020: timeout_err  output  1  one-cycle pulse on timeout.

Function
REQ-021: FSM states IDLE and GRANT.
REQ-022: In IDLE with any m_access high, the winner is registered into grant_idx and the FSM enters GRANT on the next edge.
REQ-023: RR_MODE=1: the winner is the first requester at or after rr_ptr, wrapping modulo NUM_MASTERS; rr_ptr becomes winner+1, modulo NUM_MASTERS, when the grant ends by any cause.
REQ-024: RR_MODE=0: the winner is the lowest-index requester; rr_ptr is unused.
REQ-025: In GRANT, q_m_addr/data_out/wr_en/bytesel are driven combinationally from master grant_idx.
REQ-026: In GRANT, q_m_access = m_access[grant_idx] & ~q_m_ack.
REQ-027: In IDLE, q_m_access=0, q_m_wr_en=0, q_m_data_out=0, q_m_bytesel=all-ones, q_m_addr=0.
REQ-028: When q_m_ack is high in GRANT, m_ack[grant_idx]=1 and m_data_in[grant_idx]=q_m_data_in in that same cycle, and the FSM returns to IDLE.
REQ-029: Non-owning masters always see m_ack=0 and m_data_in=0.
REQ-030: Minimum latency is request in cycle 0, q_m_access in cycle 1, earliest m_ack in cycle 1; back-to-back grants have one IDLE cycle between them.
REQ-031: If m_access[grant_idx] drops in GRANT without q_m_ack, the FSM returns to IDLE with no ack and rr_ptr advances.
REQ-032: A 16-bit wait counter clears on entry to GRANT and increments each GRANT cycle without q_m_ack.
REQ-033: When the wait counter equals TIMEOUT-1 without q_m_ack, the block asserts m_ack[grant_idx], m_data_in[grant_idx]=all-ones and timeout_err for one cycle, then enters IDLE.
REQ-034: If q_m_ack and timeout coincide, the normal ack takes priority and timeout_err stays 0.
REQ-035: q_m_ack arriving in IDLE is ignored.

Reset
REQ-036: Reset forces state=IDLE, grant_idx=0, rr_ptr=0, wait counter=0, timeout_err=0, and all m_ack=0.
REQ-037: Reset asserted mid-GRANT aborts the transaction immediately; no ack is issued and q_m_access drops asynchronously.

Structure
REQ-038: Package arb_pkg holds the state enum (IDLE, GRANT) and the default parameter constants.
REQ-039: Sub-module rr_pick is a combinational rotating priority encoder (inputs req, base; outputs idx, valid), shared by both modes with base=0 when RR_MODE=0.

Verification
REQ-040: NUM_MASTERS=2, RR_MODE=1, both request constantly, slave acks 1 cycle after access -> grants alternate 0,1,0,1; each m_ack carries the slave data.
REQ-041: NUM_MASTERS=4, RR_MODE=0, masters 1 and 3 request -> master 1 served first; master 3 is served only after master 1 deasserts.
REQ-042: TIMEOUT=8, slave never acks -> m_ack pulses 8 cycles after GRANT entry with data 16'hFFFF, timeout_err=1 for one cycle, and the next requester is granted.
REQ-043: TIMEOUT=8, q_m_ack arrives on the 8th GRANT cycle -> normal data is returned and timeout_err=0.
REQ-044: Reset pulsed while GRANT is waiting -> q_m_access=0 at once, no m_ack, and grant_idx=0 after release.
REQ-045: Master 1 writes addr 0x5000, bytesel 2'b01, data 0xABCD -> q_m_* reflects these exactly while q_m_access is high, and q_m_access drops in the ack cycle.
